leiwand_rv32_wb_uart_tx: RTL

//  Wishbone slave UART transmitter on the core's shared data bus, decoded beside internal_sram/internal_rom.

---
 rtl/leiwand_rv32_wb_uart_tx_pkg.sv | 24 ++
 rtl/leiwand_rv32_sync_fifo.sv | 50 +++++
 rtl/leiwand_rv32_wb_uart_tx.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/leiwand_rv32_wb_uart_tx_pkg.sv
// Shared constants for the Wishbone UART transmitter: register map, STATUS layout
// and serialiser state encoding.
package leiwand_rv32_wb_uart_tx_pkg;

   localparam logic [1:0] UART_ADDR_TXDATA   = 2'd0;
   localparam logic [1:0] UART_ADDR_STATUS   = 2'd1;
   localparam logic [1:0] UART_ADDR_BAUD_DIV = 2'd2;

   localparam int UART_STAT_BUSY      = 0;
   localparam int UART_STAT_FULL      = 1;
   localparam int UART_STAT_EMPTY     = 2;
   localparam int UART_STAT_OVR       = 3;
   localparam int UART_STAT_COUNT_LSB = 8;

   localparam int UART_DIV_WIDTH = 16;

   typedef enum logic [1:0] {
      TxIdle,
      TxStart,
      TxData,
      TxStop
   } tx_state_e;

endpackage

// File: rtl/leiwand_rv32_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a push into a full FIFO is accepted
// when a pop happens in the same cycle.
module leiwand_rv32_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           pushData_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           popData_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AddrW = $clog2(DEPTH);
   localparam logic [AddrW:0] PtrOne = 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AddrW:0]   wrPtr_q;
   logic [AddrW:0]   rdPtr_q;
   logic             doPush;
   logic             doPop;

   assign empty_o   = (wrPtr_q == rdPtr_q);
   assign full_o    = (wrPtr_q[AddrW] != rdPtr_q[AddrW]) &&
                      (wrPtr_q[AddrW-1:0] == rdPtr_q[AddrW-1:0]);
   assign count_o   = wrPtr_q - rdPtr_q;
   assign doPop     = pop_i && !empty_o;
   assign doPush    = push_i && (!full_o || doPop);
   assign popData_o = mem_q[rdPtr_q[AddrW-1:0]];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
      end else begin
         if (doPush) wrPtr_q <= wrPtr_q + PtrOne;
         if (doPop)  rdPtr_q <= rdPtr_q + PtrOne;
      end
   end

   // Storage needs no reset: the pointers alone define which entries are valid.
   always_ff @(posedge clk_i) begin
      if (doPush) mem_q[wrPtr_q[AddrW-1:0]] <= pushData_i;
   end

endmodule

// File: rtl/leiwand_rv32_wb_uart_tx.sv
// Wishbone slave console UART: bus register block feeding a TX FIFO that an 8N1
// serialiser drains at a programmable clocks-per-bit divider.
module leiwand_rv32_wb_uart_tx
   import leiwand_rv32_wb_uart_tx_pkg::*;
#(
   parameter int MEM_WIDTH   = 32,
   parameter int FIFO_DEPTH  = 16,
   parameter int DEFAULT_DIV = 433
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           wb_addr,
   input  logic [MEM_WIDTH-1:0] wb_data_in,
   output logic [MEM_WIDTH-1:0] wb_data_out,
   input  logic                 wb_we,
   input  logic                 wb_stb,
   output logic                 wb_ack,
   input  logic                 wb_cyc,
   output logic                 wb_stall,
   output logic                 uart_tx
);

   localparam int CntW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [UART_DIV_WIDTH-1:0] DivReset = UART_DIV_WIDTH'(DEFAULT_DIV);
   localparam logic [UART_DIV_WIDTH-1:0] DivOne   = 1;

   logic                      ack_q;
   logic [MEM_WIDTH-1:0]      rdata_q;
   logic [UART_DIV_WIDTH-1:0] baudDiv_q;
   logic                      ovr_q;

   tx_state_e                 state_q;
   logic [UART_DIV_WIDTH-1:0] baudCnt_q;
   logic [UART_DIV_WIDTH-1:0] divLatch_q;
   logic [2:0]                bitCnt_q;
   logic [7:0]                shift_q;
   logic                      tx_q;

   logic                      busAccess;
   logic                      busWrite;
   logic [MEM_WIDTH-1:0]      readMux;
   logic                      fifoPush;
   logic                      fifoPop;
   logic                      fifoFull;
   logic                      fifoEmpty;
   logic [7:0]                fifoData;
   logic [CntW-1:0]           fifoCount;
   logic                      bitDone;
   logic                      ovrSet;
   logic                      ovrClr;
   logic                      unused_ok;

   assign busAccess = wb_cyc && wb_stb && !ack_q;
   assign busWrite  = busAccess && wb_we;
   assign fifoPush  = busWrite && (wb_addr == UART_ADDR_TXDATA);
   assign bitDone   = (baudCnt_q == divLatch_q);
   // The serialiser takes a byte either from idle or straight out of a stop bit,
   // so queued bytes go out with no gap between frames.
   assign fifoPop   = !fifoEmpty &&
                      ((state_q == TxIdle) || ((state_q == TxStop) && bitDone));
   assign ovrSet    = fifoPush && fifoFull && !fifoPop;
   assign ovrClr    = busWrite && (wb_addr == UART_ADDR_STATUS) && wb_data_in[UART_STAT_OVR];

   assign wb_ack      = ack_q;
   assign wb_data_out = rdata_q;
   assign wb_stall    = 1'b0;
   assign uart_tx     = tx_q;
   assign unused_ok   = ^wb_data_in[MEM_WIDTH-1:UART_DIV_WIDTH];

   leiwand_rv32_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_txFifo (
      .clk_i      (clk),
      .rst_ni     (reset),
      .push_i     (fifoPush),
      .pushData_i (wb_data_in[7:0]),
      .pop_i      (fifoPop),
      .popData_o  (fifoData),
      .full_o     (fifoFull),
      .empty_o    (fifoEmpty),
      .count_o    (fifoCount)
   );

   always_comb begin
      readMux = '0;
      case (wb_addr)
         UART_ADDR_STATUS: begin
            readMux[UART_STAT_BUSY]                = (state_q != TxIdle);
            readMux[UART_STAT_FULL]                = fifoFull;
            readMux[UART_STAT_EMPTY]               = fifoEmpty;
            readMux[UART_STAT_OVR]                 = ovr_q;
            readMux[UART_STAT_COUNT_LSB +: 8]      = 8'(fifoCount);
         end
         UART_ADDR_BAUD_DIV: readMux[UART_DIV_WIDTH-1:0] = baudDiv_q;
         default: ;
      endcase
   end

   // Read data only carries a value in the ack cycle so the bus can OR slaves.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ack_q     <= 1'b0;
         rdata_q   <= '0;
         baudDiv_q <= DivReset;
         ovr_q     <= 1'b0;
      end else begin
         ack_q   <= busAccess;
         rdata_q <= (busAccess && !wb_we) ? readMux : '0;
         if (busWrite && (wb_addr == UART_ADDR_BAUD_DIV)) begin
            baudDiv_q <= wb_data_in[UART_DIV_WIDTH-1:0];
         end
         if (ovrSet) begin
            ovr_q <= 1'b1;
         end else if (ovrClr) begin
            ovr_q <= 1'b0;
         end
      end
   end

   // Divider is latched per frame so a BAUD_DIV write never stretches a live frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= TxIdle;
         baudCnt_q  <= '0;
         divLatch_q <= '0;
         bitCnt_q   <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
      end else begin
         case (state_q)
            TxIdle: begin
               if (fifoPop) begin
                  state_q    <= TxStart;
                  shift_q    <= fifoData;
                  divLatch_q <= baudDiv_q;
                  baudCnt_q  <= '0;
                  tx_q       <= 1'b0;
               end
            end
            TxStart: begin
               if (bitDone) begin
                  state_q   <= TxData;
                  baudCnt_q <= '0;
                  bitCnt_q  <= '0;
                  tx_q      <= shift_q[0];
                  shift_q   <= {1'b0, shift_q[7:1]};
               end else begin
                  baudCnt_q <= baudCnt_q + DivOne;
               end
            end
            TxData: begin
               if (bitDone) begin
                  baudCnt_q <= '0;
                  if (bitCnt_q == 3'd7) begin
                     state_q <= TxStop;
                     tx_q    <= 1'b1;
                  end else begin
                     bitCnt_q <= bitCnt_q + 3'd1;
                     tx_q     <= shift_q[0];
                     shift_q  <= {1'b0, shift_q[7:1]};
                  end
               end else begin
                  baudCnt_q <= baudCnt_q + DivOne;
               end
            end
            TxStop: begin
               if (bitDone) begin
                  baudCnt_q <= '0;
                  if (fifoPop) begin
                     state_q    <= TxStart;
                     shift_q    <= fifoData;
                     divLatch_q <= baudDiv_q;
                     tx_q       <= 1'b0;
                  end else begin
                     state_q <= TxIdle;
                  end
               end else begin
                  baudCnt_q <= baudCnt_q + DivOne;
               end
            end
            default: state_q <= TxIdle;
         endcase
      end
   end

endmodule
